// File: rtl/skin_decider.sv
// Per-pixel YCbCr skin-tone classifier with a registered one-bit flag.
// Optional luma window gate enabled by defining SKIN_LUMA_GATE_EN.
module skin_decider #(
    parameter int unsigned CB_MIN   = 77,
    parameter int unsigned CB_MAX   = 127,
    parameter int unsigned CR_MIN   = 133,
    parameter int unsigned CR_MAX   = 173,
    parameter int unsigned LUMA_MIN = 40,
    parameter int unsigned LUMA_MAX = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] luma_ch,
    input  logic [7:0] cb_ch,
    input  logic [7:0] cr_ch,
    output logic       skin_pix
);

    localparam int unsigned CMP_W = 32;

    logic cb_in;
    logic cr_in;
    logic luma_in;
    logic hit;

    // Inclusive windows compared at full parameter width, so MIN > MAX never matches
    assign cb_in = (CMP_W'(cb_ch) >= CB_MIN) && (CMP_W'(cb_ch) <= CB_MAX);
    assign cr_in = (CMP_W'(cr_ch) >= CR_MIN) && (CMP_W'(cr_ch) <= CR_MAX);

`ifdef SKIN_LUMA_GATE_EN
    assign luma_in = (CMP_W'(luma_ch) >= LUMA_MIN) && (CMP_W'(luma_ch) <= LUMA_MAX);
`else
    logic luma_unused;
    assign luma_unused = ^{luma_ch, CMP_W'(LUMA_MIN), CMP_W'(LUMA_MAX)};
    assign luma_in     = 1'b1;
`endif

    assign hit = cb_in && cr_in && luma_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            skin_pix <= 1'b0;
        end else begin
            skin_pix <= hit;
        end
    end

endmodule

// File: tb/tb_skin_decider.sv
// Directed self-checking bench for skin_decider; expectations follow the
// SKIN_LUMA_GATE_EN setting of the build.
module tb_skin_decider;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] luma_ch;
    logic [7:0] cb_ch;
    logic [7:0] cr_ch;
    logic       skin_pix;

    int checks   = 0;
    int failures = 0;

`ifdef SKIN_LUMA_GATE_EN
    localparam logic LUMA_GATE = 1'b1;
`else
    localparam logic LUMA_GATE = 1'b0;
`endif

    skin_decider dut (
        .clk     (clk),
        .rst     (rst),
        .luma_ch (luma_ch),
        .cb_ch   (cb_ch),
        .cr_ch   (cr_ch),
        .skin_pix(skin_pix)
    );

    always #5 clk = ~clk;

    // Drive one pixel mid-cycle, then check the flag just after the next rising edge
    task automatic step(input logic r, input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr, input logic exp, input string tag);
        @(negedge clk);
        rst     = r;
        luma_ch = y;
        cb_ch   = cb;
        cr_ch   = cr;
        @(posedge clk);
        #1;
        checks++;
        assert (skin_pix === exp) else begin
            failures++;
            $error("FAIL %s: skin_pix=%b expected=%b", tag, skin_pix, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        luma_ch = 8'd0;
        cb_ch   = 8'd0;
        cr_ch   = 8'd0;

        step(1'b1, 8'd123, 8'd100, 8'd150, 1'b0, "reset_c1");
        step(1'b1, 8'd123, 8'd100, 8'd150, 1'b0, "reset_c2");
        step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "reset_release");

        step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "nominal_skin");
        step(1'b0, 8'd123, 8'd145, 8'd190, 1'b0, "nominal_cb_out");
        step(1'b0, 8'd0,   8'd0,   8'd0,   1'b0, "nominal_zero");
        step(1'b0, 8'd123, 8'd167, 8'd0,   1'b0, "nominal_cr_zero");

        step(1'b0, 8'd123, 8'd77,  8'd133, 1'b1, "bound_min");
        step(1'b0, 8'd123, 8'd76,  8'd133, 1'b0, "bound_cb_below");
        step(1'b0, 8'd123, 8'd127, 8'd173, 1'b1, "bound_max");
        step(1'b0, 8'd123, 8'd128, 8'd173, 1'b0, "bound_cb_above");
        step(1'b0, 8'd123, 8'd100, 8'd132, 1'b0, "bound_cr_below");
        step(1'b0, 8'd123, 8'd100, 8'd174, 1'b0, "bound_cr_above");

        step(1'b0, 8'd250, 8'd100, 8'd150, !LUMA_GATE, "luma_bright");
        step(1'b0, 8'd40,  8'd100, 8'd150, 1'b1,       "luma_min_edge");
        step(1'b0, 8'd39,  8'd100, 8'd150, !LUMA_GATE, "luma_dark");
        step(1'b0, 8'd240, 8'd100, 8'd150, 1'b1,       "luma_max_edge");

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "b2b_skin");
            else
                step(1'b0, 8'd123, 8'd177, 8'd230, 1'b0, "b2b_non_skin");
        end

        step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "mid_pre");
        step(1'b1, 8'd123, 8'd100, 8'd150, 1'b0, "mid_reset");
        step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "mid_resume1");
        step(1'b0, 8'd123, 8'd100, 8'd150, 1'b1, "mid_resume2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
